// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter, data priority over fetch.
// Optional fetch anti-starvation counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_read
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data port owns the access
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              force_if;
  logic              accept;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_if = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Counts data grants taken while fetch is waiting; saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (d_gnt && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign d_gnt  = d_req & ~force_if & ~reset;
  assign if_gnt = if_req & (~d_req | force_if) & ~reset;
  assign accept = d_gnt | if_gnt;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    if (state_q == ACCESS) begin
      if (owner_q) begin
        d_rdata_d = mem_read;
        d_valid_d = 1'b1;
      end else begin
        if_rdata_d = mem_read;
        if_valid_d = 1'b1;
      end
    end

    if (accept) begin
      state_d    = ACCESS;
      owner_d    = d_gnt;
      mem_addr_d = d_gnt ? d_addr : if_addr;
      mem_we_d   = d_gnt & d_we;
      if (d_gnt) begin
        mem_wdata_d = d_wdata;
      end
    end else begin
      state_d  = IDLE;
      mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter.
// Honours MEM_ARB_FAIRNESS_EN to select the expected arbitration policy.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_valid, d_gnt, d_valid, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_read;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  assign mem_read = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    if_req = 1'b1;
    d_req  = 1'b1;
    #1;
    checks += 9;
    if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%0b exp=0", if_gnt); end
    if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got=%0b exp=0", d_gnt); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    if (d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%0b exp=0", d_valid); end
    if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
    if (if_rdata !== '0) begin failures++; $display("FAIL reset_if_rdata got=%0h exp=0", if_rdata); end
    if (d_rdata !== '0) begin failures++; $display("FAIL reset_d_rdata got=%0h exp=0", d_rdata); end
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    mem[32] = 32'd12;
    tick();
    if_req  = 1'b1;
    if_addr = 32'h80;
    #1;
    checks += 2;
    if (if_gnt !== 1'b1) begin failures++; $display("FAIL fetch_if_gnt got=%0b exp=1", if_gnt); end
    if (d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_d_gnt got=%0b exp=0", d_gnt); end
    tick();
    idle_inputs();
    #1;
    checks += 3;
    if (mem_addr !== 32'h80) begin failures++; $display("FAIL fetch_mem_addr got=%0h exp=80", mem_addr); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL fetch_mem_we got=%0b exp=0", mem_we); end
    if (if_valid !== 1'b0) begin failures++; $display("FAIL fetch_early_valid got=%0b exp=0", if_valid); end
    tick();
    checks += 3;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL fetch_if_valid got=%0b exp=1", if_valid); end
    if (if_rdata !== 32'd12) begin failures++; $display("FAIL fetch_if_rdata got=%0d exp=12", if_rdata); end
    if (d_valid !== 1'b0) begin failures++; $display("FAIL fetch_d_valid got=%0b exp=0", d_valid); end
    tick();
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL fetch_valid_pulse got=%0b exp=0", if_valid); end
  endtask

  task automatic test_store_load();
    mem[4] = 32'h55;
    tick();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_wdata = 32'd15;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL store_d_gnt got=%0b exp=1", d_gnt); end
    tick();
    idle_inputs();
    #1;
    checks += 3;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL store_mem_we got=%0b exp=1", mem_we); end
    if (mem_addr !== 32'h10) begin failures++; $display("FAIL store_mem_addr got=%0h exp=10", mem_addr); end
    if (mem_wdata !== 32'd15) begin failures++; $display("FAIL store_mem_wdata got=%0d exp=15", mem_wdata); end
    tick();
    checks += 4;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL store_we_one_cycle got=%0b exp=0", mem_we); end
    if (d_valid !== 1'b1) begin failures++; $display("FAIL store_d_valid got=%0b exp=1", d_valid); end
    if (d_rdata !== 32'h55) begin failures++; $display("FAIL store_prewrite_rdata got=%0h exp=55", d_rdata); end
    if (mem[4] !== 32'd15) begin failures++; $display("FAIL store_committed got=%0d exp=15", mem[4]); end
    tick();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h10;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL load_d_gnt got=%0b exp=1", d_gnt); end
    tick();
    idle_inputs();
    tick();
    checks += 2;
    if (d_valid !== 1'b1) begin failures++; $display("FAIL load_d_valid got=%0b exp=1", d_valid); end
    if (d_rdata !== 32'd15) begin failures++; $display("FAIL load_d_rdata got=%0d exp=15", d_rdata); end
  endtask

  task automatic test_contention();
    tick();
    if_req  = 1'b1;
    if_addr = 32'h80;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h10;
    #1;
    checks += 2;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL cont_d_gnt got=%0b exp=1", d_gnt); end
    if (if_gnt !== 1'b0) begin failures++; $display("FAIL cont_if_gnt got=%0b exp=0", if_gnt); end
    tick();
    d_req = 1'b0;
    #1;
    checks += 2;
    if (if_gnt !== 1'b1) begin failures++; $display("FAIL cont_if_gnt_after got=%0b exp=1", if_gnt); end
    if (mem_addr !== 32'h10) begin failures++; $display("FAIL cont_mem_addr_d got=%0h exp=10", mem_addr); end
    tick();
    idle_inputs();
    #1;
    checks += 3;
    if (d_valid !== 1'b1) begin failures++; $display("FAIL cont_d_valid got=%0b exp=1", d_valid); end
    if (d_rdata !== 32'd15) begin failures++; $display("FAIL cont_d_rdata got=%0d exp=15", d_rdata); end
    if (mem_addr !== 32'h80) begin failures++; $display("FAIL cont_mem_addr_if got=%0h exp=80", mem_addr); end
    tick();
    checks += 3;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL cont_if_valid got=%0b exp=1", if_valid); end
    if (if_rdata !== 32'd12) begin failures++; $display("FAIL cont_if_rdata got=%0d exp=12", if_rdata); end
    if (d_valid !== 1'b0) begin failures++; $display("FAIL cont_d_valid_end got=%0b exp=0", d_valid); end
  endtask

  task automatic test_starvation();
    int  n_if;
    int  exp_n;
    logic exp_ig;
    n_if = 0;
    tick();
    idle_inputs();
    tick();
    if_req  = 1'b1;
    if_addr = 32'h80;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h10;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef MEM_ARB_FAIRNESS_EN
      exp_ig = ((k % (LIM + 1)) == LIM);
`else
      exp_ig = 1'b0;
`endif
      if (if_gnt === 1'b1) n_if++;
      checks += 2;
      if (if_gnt !== exp_ig) begin failures++; $display("FAIL starve_if_gnt k=%0d got=%0b exp=%0b", k, if_gnt, exp_ig); end
      if (d_gnt !== ~exp_ig) begin failures++; $display("FAIL starve_d_gnt k=%0d got=%0b exp=%0b", k, d_gnt, ~exp_ig); end
      tick();
    end
    idle_inputs();
`ifdef MEM_ARB_FAIRNESS_EN
    exp_n = 10 / (LIM + 1);
`else
    exp_n = 0;
`endif
    checks++;
    if (n_if != exp_n) begin failures++; $display("FAIL starve_fetch_count got=%0d exp=%0d", n_if, exp_n); end
    tick();
    tick();
  endtask

  task automatic test_abort();
    mem[8] = 32'hAA;
    tick();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h77;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL abort_d_gnt got=%0b exp=1", d_gnt); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL abort_we_before got=%0b exp=1", mem_we); end
    #2;
    reset = 1'b1;
    #1;
    checks += 2;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_we_drop got=%0b exp=0", mem_we); end
    if (mem_addr !== '0) begin failures++; $display("FAIL abort_mem_addr got=%0h exp=0", mem_addr); end
    @(posedge clk);
    #1;
    checks += 2;
    if (mem[8] !== 32'hAA) begin failures++; $display("FAIL abort_mem_word got=%0h exp=aa", mem[8]); end
    if (d_valid !== 1'b0) begin failures++; $display("FAIL abort_d_valid got=%0b exp=0", d_valid); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks += 2;
    if (d_valid !== 1'b0) begin failures++; $display("FAIL abort_d_valid_after got=%0b exp=0", d_valid); end
    if (mem[8] !== 32'hAA) begin failures++; $display("FAIL abort_mem_after got=%0h exp=aa", mem[8]); end
  endtask

  // Transaction-level reference: each grant becomes one access, which
  // completes one cycle later with the word the memory held before any write.
  task automatic test_random(input int n);
    logic          acc_v, acc_d, acc_we;
    int            acc_idx;
    logic [DW-1:0] acc_wd;
    logic          g_v, g_d, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_ird, e_drd, w;
    logic          e_we, e_iv, e_dv, e_ig, e_dg, frc;
    int            starve;

    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    acc_v = 0; acc_d = 0; acc_we = 0; acc_idx = 0; acc_wd = '0;
    g_v = 0; g_d = 0; g_we = 0; g_addr = '0; g_wd = '0;
    e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
    e_we = 0; e_iv = 0; e_dv = 0; starve = 0;

    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      e_iv = 1'b0;
      e_dv = 1'b0;
      if (acc_v) begin
        w = ref_mem[acc_idx];
        if (acc_d) begin e_drd = w; e_dv = 1'b1; end
        else begin e_ird = w; e_iv = 1'b1; end
        if (acc_we) ref_mem[acc_idx] = acc_wd;
      end
      acc_v   = g_v;
      acc_d   = g_d;
      acc_we  = g_v & g_d & g_we;
      acc_idx = int'(g_addr[9:2]);
      acc_wd  = g_wd;
      e_we    = acc_we;
      if (g_v) e_addr = g_addr;
      if (g_v && g_d) e_wdata = g_wd;
      if (!if_req || (g_v && !g_d)) starve = 0;
      else if (g_v && g_d && starve < LIM) starve++;
      #1;
      if (!(if_req && !(g_v && !g_d))) if_addr = $urandom & 32'hFFFF_FFFC;
      if_req  = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
`ifdef MEM_ARB_FAIRNESS_EN
      frc = (starve == LIM);
`else
      frc = 1'b0;
`endif
      e_dg   = d_req & ~frc;
      e_ig   = if_req & (~d_req | frc);
      g_v    = e_dg | e_ig;
      g_d    = e_dg;
      g_we   = d_we;
      g_addr = e_dg ? d_addr : if_addr;
      g_wd   = d_wdata;
      @(negedge clk);
      checks += 8;
      if (if_gnt !== e_ig) begin failures++; $display("FAIL rnd_if_gnt c=%0d got=%0b exp=%0b", c, if_gnt, e_ig); end
      if (d_gnt !== e_dg) begin failures++; $display("FAIL rnd_d_gnt c=%0d got=%0b exp=%0b", c, d_gnt, e_dg); end
      if (mem_we !== e_we) begin failures++; $display("FAIL rnd_mem_we c=%0d got=%0b exp=%0b", c, mem_we, e_we); end
      if (mem_addr !== e_addr) begin failures++; $display("FAIL rnd_mem_addr c=%0d got=%0h exp=%0h", c, mem_addr, e_addr); end
      if (if_valid !== e_iv) begin failures++; $display("FAIL rnd_if_valid c=%0d got=%0b exp=%0b", c, if_valid, e_iv); end
      if (d_valid !== e_dv) begin failures++; $display("FAIL rnd_d_valid c=%0d got=%0b exp=%0b", c, d_valid, e_dv); end
      if (if_rdata !== e_ird) begin failures++; $display("FAIL rnd_if_rdata c=%0d got=%0h exp=%0h", c, if_rdata, e_ird); end
      if (d_rdata !== e_drd) begin failures++; $display("FAIL rnd_d_rdata c=%0d got=%0h exp=%0h", c, d_rdata, e_drd); end
      if (e_we) begin
        checks++;
        if (mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_mem_wdata c=%0d got=%0h exp=%0h", c, mem_wdata, e_wdata); end
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #2;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_reset();
    test_starvation();
    test_abort();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port access arbiter for the combined instruction/data memory. It shares the memory's one address/write port between the instruction-fetch requester and the load/store (data) requester, and gives data priority over fetch. It registers each accepted request into a one-cycle memory access, captures the read word, and returns it to the owner with a one-cycle valid pulse. It sits between the CPU front end / load-store logic and `combined memory`.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data word width.
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while fetch waits. Used only with the fairness feature; minimum 1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; `if_addr` is stable while high.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_valid`  out  1  one-cycle pulse: `if_rdata` is valid.
- `if_rdata`  out  DATA_W  fetched word.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_valid`  out  1  one-cycle pulse: load data valid or store done.
- `d_rdata`  out  DATA_W  loaded word.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  DATA_W  memory write data, registered.
- `mem_we`  out  1  memory write enable, registered.
- `mem_read`  in  DATA_W  memory combinational read data.

## Operation
- **Handshake.** A request transfers on a rising edge where `x_req` and `x_gnt` are both 1. After that edge the requester may change `addr`/`wdata` or drop `req`. If it holds `req` high, that is a new request.
- **Arbitration.** Every cycle, including access cycles, at most one grant is given:
  - `d_gnt = d_req & ~force_if`.
  - `if_gnt = if_req & (~d_req | force_if)`.
  - Both grants are 0 while `reset` is high.
- **State.** Two states, IDLE and ACCESS.
  - On an accepting edge: go to ACCESS, latch `owner`, the address, `d_we & owner==D`, and the write data onto the `mem_*` registers.
  - ACCESS with no accepting edge: go to IDLE and clear `mem_we`. `mem_addr` and `mem_wdata` keep their last values.
  - ACCESS with an accepting edge: stay in ACCESS with the new owner (back-to-back).
- **Completion.** At the end of each ACCESS cycle:
  - `mem_read` is registered into the owner's `rdata`.
  - The owner's `valid` is set for the next cycle. The other port's `rdata` is unchanged.
- **Stores.** `d_valid` pulses for stores too. `d_rdata` holds the pre-write word, because the memory read is combinational and the write commits on the same edge.
- **Fetch never writes.** `mem_we` is 0 during fetch accesses.
- **Addresses** pass through unmodified. Word selection and alignment are the memory's responsibility.

## Timing
- Reset values:
  - state IDLE;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` all 0;
  - `mem_we`, `if_valid`, `d_valid` all 0;
  - starvation counter 0.
- Latency:
  - Request granted in cycle N.
  - Memory access in cycle N+1.
  - `x_valid` and `x_rdata` in cycle N+2.
- Throughput is one access per cycle. Sustained back-to-back grants never insert an idle cycle.
- Simultaneous `if_req` and `d_req`: data wins unless `force_if` is set. Fetch stays pending with `if_gnt` = 0.
- Reset asserted mid-access: `mem_we` drops immediately, so an uncommitted store is lost and no `valid` pulse is issued. Nothing is granted until the first edge after `reset` falls.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A saturating counter increments on each data grant while `if_req` = 1.
  - The counter clears on any fetch grant or any cycle with `if_req` = 0.
  - `force_if` = (counter == `STARVE_LIMIT`). Fetch then wins the next arbitration even if `d_req` = 1.
- `MEM_ARB_FAIRNESS_EN` undefined:
  - `force_if` is constant 0 and the counter is not built.
  - Strict data priority; fetch may starve indefinitely.

## Test plan
- **Reset.** Assert `reset` mid-simulation → all outputs take their reset values immediately, both `gnt` are 0, and `mem_we` = 0.
- **Single fetch.** `if_req` with `if_addr`=0x80, memory word 32 = 12 → `if_gnt` in cycle 0, `mem_addr`=0x80 in cycle 1, `if_valid`=1 and `if_rdata`=12 in cycle 2.
- **Store then load.**
  - Store: `d_we`=1, `d_addr`=0x10, `d_wdata`=15 → `mem_we`=1 for exactly one cycle, then `d_valid`.
  - Load: `d_we`=0 at 0x10 → `d_rdata`=15.
- **Contention.** `if_req` and `d_req` both high in the same cycle → `d_gnt`=1 and `if_gnt`=0. Fetch is granted the cycle after `d_req` drops. Two valids arrive in consecutive cycles with no idle gap.
- **Starvation.** `d_req` held high for 10 cycles with `if_req` high:
  - With `MEM_ARB_FAIRNESS_EN` and `STARVE_LIMIT`=4: fetch is granted after every 4 data grants.
  - Without the macro: no fetch grant occurs.
- **Abort.** Raise `reset` during a store access cycle, before the clock edge → the target memory word is unchanged and `d_valid` never pulses.
